// File: rtl/carregador_instrucoes_if.sv
// carregador_instrucoes_if: host byte stream plus instruction memory write port
interface carregador_instrucoes_if;
  logic [7:0] dado_in;
  logic       dado_valido;
  logic       dado_pronto;
  logic       mem_escreve;
  logic [7:0] mem_endereco;
  logic [7:0] mem_dado;
  modport master (output dado_in, dado_valido, input dado_pronto, mem_escreve, mem_endereco, mem_dado);
  modport slave (input dado_in, dado_valido, output dado_pronto, mem_escreve, mem_endereco, mem_dado);
endinterface

// File: rtl/carregador_instrucoes.sv
// carregador_instrucoes: loads a checksummed byte frame into instruction memory, pads with HALT, then releases the CPU
module carregador_instrucoes #(
  parameter int         PROFUNDIDADE = 61,
  parameter logic [7:0] HALT         = 8'b11000011
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          inicio,
  carregador_instrucoes_if.slave        bus,
  output logic                          cpu_segura,
  output logic                          ocupado,
  output logic                          concluido,
  output logic                          erro,
  output logic [7:0]                    contagem
);
  typedef enum logic [2:0] {OCIOSO, TAMANHO, DADOS, SOMA, PREENCHE, FIM, ERRO} estado_t;
  localparam logic [7:0] P      = 8'(PROFUNDIDADE);
  localparam logic [7:0] ULTIMO = 8'(PROFUNDIDADE - 1);
  estado_t    estado, estado_nx;
  logic [7:0] n, n_nx, soma, soma_nx, contagem_nx, endereco_nx, dado_nx;
  logic       pronto_nx, escreve_nx, segura_nx, ocupado_nx, concluido_nx, erro_nx;
  logic       aceita;
  assign aceita = bus.dado_valido & bus.dado_pronto;
  always_comb begin
    estado_nx    = estado;
    n_nx         = n;
    soma_nx      = soma;
    contagem_nx  = contagem;
    endereco_nx  = bus.mem_endereco;
    dado_nx      = bus.mem_dado;
    escreve_nx   = 1'b0;
    segura_nx    = cpu_segura;
    ocupado_nx   = ocupado;
    concluido_nx = concluido;
    erro_nx      = erro;
    case (estado)
      OCIOSO, FIM, ERRO: if (inicio) begin
        estado_nx    = TAMANHO;
        contagem_nx  = 8'd0;
        soma_nx      = 8'd0;
        concluido_nx = 1'b0;
        erro_nx      = 1'b0;
        ocupado_nx   = 1'b1;
        segura_nx    = 1'b1;
      end
      TAMANHO: if (aceita) begin
        if (bus.dado_in == 8'd0 || bus.dado_in > P) begin
          estado_nx  = ERRO;
          erro_nx    = 1'b1;
          ocupado_nx = 1'b0;
        end else begin
          n_nx      = bus.dado_in;
          estado_nx = DADOS;
        end
      end
      DADOS: if (aceita) begin
        escreve_nx  = 1'b1;
        endereco_nx = contagem;
        dado_nx     = bus.dado_in;
        contagem_nx = contagem + 8'd1;
        soma_nx     = soma + bus.dado_in;
        if (contagem + 8'd1 == n) estado_nx = SOMA;
      end
      SOMA: if (aceita) begin
        if (bus.dado_in != soma) begin
          estado_nx  = ERRO;
          erro_nx    = 1'b1;
          ocupado_nx = 1'b0;
        end else if (n == P) begin
          estado_nx    = FIM;
          concluido_nx = 1'b1;
          segura_nx    = 1'b0;
          ocupado_nx   = 1'b0;
        end else begin
          // first HALT write is issued on the same edge the checksum is accepted
          estado_nx   = PREENCHE;
          escreve_nx  = 1'b1;
          endereco_nx = n;
          dado_nx     = HALT;
        end
      end
      PREENCHE: if (bus.mem_endereco == ULTIMO) begin
        estado_nx    = FIM;
        concluido_nx = 1'b1;
        segura_nx    = 1'b0;
        ocupado_nx   = 1'b0;
      end else begin
        escreve_nx  = 1'b1;
        endereco_nx = bus.mem_endereco + 8'd1;
        dado_nx     = HALT;
      end
      default: ;
    endcase
    pronto_nx = estado_nx inside {TAMANHO, DADOS, SOMA};
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado           <= OCIOSO;
      n                <= 8'd0;
      soma             <= 8'd0;
      contagem         <= 8'd0;
      bus.dado_pronto  <= 1'b0;
      bus.mem_escreve  <= 1'b0;
      bus.mem_endereco <= 8'd0;
      bus.mem_dado     <= 8'd0;
      cpu_segura       <= 1'b1;
      ocupado          <= 1'b0;
      concluido        <= 1'b0;
      erro             <= 1'b0;
    end else begin
      estado           <= estado_nx;
      n                <= n_nx;
      soma             <= soma_nx;
      contagem         <= contagem_nx;
      bus.dado_pronto  <= pronto_nx;
      bus.mem_escreve  <= escreve_nx;
      bus.mem_endereco <= endereco_nx;
      bus.mem_dado     <= dado_nx;
      cpu_segura       <= segura_nx;
      ocupado          <= ocupado_nx;
      concluido        <= concluido_nx;
      erro             <= erro_nx;
    end
  end
endmodule

// File: tb/tb_carregador_instrucoes.sv
// tb_carregador_instrucoes: directed frames against hand-computed memory image and flag timing
module tb_carregador_instrucoes;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       inicio = 1'b0;
  logic       cpu_segura, ocupado, concluido, erro;
  logic [7:0] contagem;
  int         checks = 0;
  int         failures = 0;
  int         ciclo = 0;
  int         n_esc = 0;
  int         w0;
  int         bad;
  logic [7:0] mem [256];
  int         ciclo_esc [256];
  carregador_instrucoes_if bus();
  carregador_instrucoes dut (
    .clock(clock), .reset(reset), .inicio(inicio), .bus(bus),
    .cpu_segura(cpu_segura), .ocupado(ocupado), .concluido(concluido),
    .erro(erro), .contagem(contagem)
  );
  always #5 clock = ~clock;
  always @(posedge clock) begin
    ciclo <= ciclo + 1;
    if (bus.mem_escreve) begin
      n_esc <= n_esc + 1;
      mem[bus.mem_endereco] <= bus.mem_dado;
      ciclo_esc[bus.mem_endereco] <= ciclo;
    end
  end
  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_pronto"}, 32'(bus.dado_pronto), 0);
    chk({tag, "_escreve"}, 32'(bus.mem_escreve), 0);
    chk({tag, "_endereco"}, 32'(bus.mem_endereco), 0);
    chk({tag, "_dado"}, 32'(bus.mem_dado), 0);
    chk({tag, "_segura"}, 32'(cpu_segura), 1);
    chk({tag, "_ocupado"}, 32'(ocupado), 0);
    chk({tag, "_concluido"}, 32'(concluido), 0);
    chk({tag, "_erro"}, 32'(erro), 0);
    chk({tag, "_contagem"}, 32'(contagem), 0);
  endtask
  task automatic iniciar();
    inicio = 1'b1;
    @(negedge clock);
    inicio = 1'b0;
    chk("pronto_apos_inicio", 32'(bus.dado_pronto), 1);
    chk("ocupado_apos_inicio", 32'(ocupado), 1);
    chk("segura_apos_inicio", 32'(cpu_segura), 1);
  endtask
  task automatic enviar(input logic [7:0] b);
    int k;
    k = 0;
    bus.dado_in = b;
    bus.dado_valido = 1'b1;
    while (!bus.dado_pronto && k < 20) begin
      @(negedge clock);
      k++;
    end
    chk("consumo", 32'(bus.dado_pronto), 1);
    @(negedge clock);
  endtask
  task automatic esperar_fim();
    int k;
    k = 0;
    while (!(concluido || erro) && k < 300) begin
      @(negedge clock);
      k++;
    end
  endtask
  initial begin
    bus.dado_in = 8'h00;
    bus.dado_valido = 1'b0;
    repeat (3) @(negedge clock);
    chk_reset("reset_inicial");
    reset = 1'b0;
    @(negedge clock);
    // abort mid-frame after two of five bytes
    iniciar();
    enviar(8'd5);
    enviar(8'h11);
    enviar(8'h22);
    bus.dado_valido = 1'b0;
    chk("contagem_parcial", 32'(contagem), 2);
    reset = 1'b1;
    @(negedge clock);
    chk_reset("reset_meio");
    reset = 1'b0;
    @(negedge clock);
    // frame A, valid held high
    iniciar();
    w0 = n_esc;
    enviar(8'd3);
    enviar(8'h98);
    enviar(8'hE8);
    enviar(8'h99);
    enviar(8'h19);
    bus.dado_valido = 1'b0;
    esperar_fim();
    chk("a_concluido_atraso", 32'(ciclo - ciclo_esc[60]), 1);
    chk("a_concluido", 32'(concluido), 1);
    chk("a_segura", 32'(cpu_segura), 0);
    chk("a_ocupado", 32'(ocupado), 0);
    chk("a_erro", 32'(erro), 0);
    chk("a_contagem", 32'(contagem), 3);
    chk("a_escritas", 32'(n_esc - w0), 61);
    chk("a_mem0", 32'(mem[0]), 32'h98);
    chk("a_mem1", 32'(mem[1]), 32'hE8);
    chk("a_mem2", 32'(mem[2]), 32'h99);
    chk("a_seq01", 32'(ciclo_esc[1] - ciclo_esc[0]), 1);
    chk("a_seq12", 32'(ciclo_esc[2] - ciclo_esc[1]), 1);
    chk("a_seq23", 32'(ciclo_esc[3] - ciclo_esc[2]), 1);
    chk("a_seq3_60", 32'(ciclo_esc[60] - ciclo_esc[3]), 57);
    bad = 0;
    for (int a = 3; a <= 60; a++) if (mem[a] !== 8'hC3) bad++;
    chk("a_halt", 32'(bad), 0);
    chk("a_pronto_fim", 32'(bus.dado_pronto), 0);
    // same frame, wrong checksum
    iniciar();
    w0 = n_esc;
    enviar(8'd3);
    enviar(8'h98);
    enviar(8'hE8);
    enviar(8'h99);
    enviar(8'h20);
    bus.dado_valido = 1'b0;
    chk("b_erro", 32'(erro), 1);
    chk("b_segura", 32'(cpu_segura), 1);
    chk("b_ocupado", 32'(ocupado), 0);
    chk("b_concluido", 32'(concluido), 0);
    chk("b_pronto", 32'(bus.dado_pronto), 0);
    repeat (5) @(negedge clock);
    chk("b_escritas", 32'(n_esc - w0), 3);
    iniciar();
    chk("b_erro_limpo", 32'(erro), 0);
    w0 = n_esc;
    enviar(8'd3);
    enviar(8'h98);
    enviar(8'hE8);
    enviar(8'h99);
    enviar(8'h19);
    bus.dado_valido = 1'b0;
    esperar_fim();
    chk("b_recarga_concluido", 32'(concluido), 1);
    chk("b_recarga_escritas", 32'(n_esc - w0), 61);
    // illegal lengths
    iniciar();
    w0 = n_esc;
    enviar(8'd0);
    bus.dado_valido = 1'b0;
    chk("n0_erro", 32'(erro), 1);
    repeat (3) @(negedge clock);
    chk("n0_escritas", 32'(n_esc - w0), 0);
    iniciar();
    w0 = n_esc;
    enviar(8'd62);
    bus.dado_valido = 1'b0;
    chk("n62_erro", 32'(erro), 1);
    chk("n62_ocupado", 32'(ocupado), 0);
    repeat (3) @(negedge clock);
    chk("n62_escritas", 32'(n_esc - w0), 0);
    // full depth with valid gaps
    iniciar();
    w0 = n_esc;
    enviar(8'd61);
    for (int i = 0; i < 61; i++) begin
      enviar(8'h01);
      if (i % 7 == 3) begin
        bus.dado_valido = 1'b0;
        repeat (2) @(negedge clock);
      end
    end
    enviar(8'h3D);
    bus.dado_valido = 1'b0;
    esperar_fim();
    chk("cheio_concluido", 32'(concluido), 1);
    chk("cheio_segura", 32'(cpu_segura), 0);
    chk("cheio_contagem", 32'(contagem), 61);
    repeat (3) @(negedge clock);
    chk("cheio_escritas", 32'(n_esc - w0), 61);
    bad = 0;
    for (int a = 0; a <= 60; a++) if (mem[a] !== 8'h01) bad++;
    chk("cheio_mem", 32'(bad), 0);
    // 8-bit wrap of the running sum, inicio ignored during DADOS
    iniciar();
    w0 = n_esc;
    enviar(8'd2);
    enviar(8'hFF);
    inicio = 1'b1;
    enviar(8'h02);
    inicio = 1'b0;
    chk("wrap_contagem", 32'(contagem), 2);
    chk("wrap_ocupado", 32'(ocupado), 1);
    enviar(8'h01);
    bus.dado_valido = 1'b0;
    esperar_fim();
    chk("wrap_concluido", 32'(concluido), 1);
    chk("wrap_erro", 32'(erro), 0);
    chk("wrap_escritas", 32'(n_esc - w0), 61);
    chk("wrap_mem0", 32'(mem[0]), 32'hFF);
    chk("wrap_mem1", 32'(mem[1]), 32'h02);
    chk("wrap_mem2", 32'(mem[2]), 32'hC3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/carregador_instrucoes.md
# carregador_instrucoes

Program loader for the 8-bit processor: accepts a byte stream from a host over a valid/ready handshake and writes it into instruction memory. Holds the CPU stopped while loading, verifies an 8-bit checksum, pads unused addresses with HALT, then releases the CPU. Sits between the host/testbench byte source and the instruction memory write port. This is the writer counterpart to the processor's instruction fetch path.

## Interface
- PROFUNDIDADE, 61, instruction memory depth in words (addresses 0..PROFUNDIDADE-1, max 255)
- HALT, 8'b11000011, instruction word written to every address not loaded
- clock  in  1  system clock, all state changes on posedge
- reset  in  1  asynchronous, active-high; one clock, reset is asynchronous and active-high
- inicio  in  1  start request, sampled on posedge
- dado_in  in  8  host byte
- dado_valido  in  1  host byte valid
- dado_pronto  out  1  loader ready to accept byte
- mem_escreve  out  1  instruction memory write enable
- mem_endereco  out  8  write address
- mem_dado  out  8  write data
- cpu_segura  out  1  1 = CPU held in reset/stopped
- ocupado  out  1  load in progress
- concluido  out  1  load finished, checksum OK
- erro  out  1  load aborted
- contagem  out  8  instruction bytes accepted in current load

## Operation
- Frame: length byte N, then N instruction bytes (stored at addresses 0..N-1), then checksum byte = sum of the N instruction bytes mod 256.
- Byte transfer occurs on a posedge where dado_valido=1 and dado_pronto=1; otherwise the byte is not consumed.
- States: OCIOSO, TAMANHO, DADOS, SOMA, PREENCHE, FIM, ERRO.
- OCIOSO: inicio=1 -> TAMANHO; clear contagem, the running sum, concluido, and erro; set ocupado.
- TAMANHO: accept N. If N==0 or N>PROFUNDIDADE -> ERRO. Otherwise latch N -> DADOS.
- DADOS: each accepted byte is written to address contagem; contagem+1; the running sum += byte (8-bit wrap). After the Nth byte -> SOMA.
- SOMA: accept one byte. If it equals the running sum: -> PREENCHE when N<PROFUNDIDADE, -> FIM when N==PROFUNDIDADE. Otherwise -> ERRO.
- PREENCHE: write HALT at addresses N..PROFUNDIDADE-1, one per cycle; after the last write -> FIM.
- FIM: concluido=1, cpu_segura=0, ocupado=0.
- ERRO: erro=1, cpu_segura=1, ocupado=0. Addresses already written are left as-is.
- inicio in FIM or ERRO restarts the load (-> TAMANHO, same clears as from OCIOSO, cpu_segura=1). inicio in TAMANHO, DADOS, SOMA, or PREENCHE is ignored.
- dado_pronto=1 only in TAMANHO, DADOS, and SOMA. Bytes offered in any other state are not consumed.

## Timing
- Reset values: dado_pronto=0, mem_escreve=0, mem_endereco=0, mem_dado=0, cpu_segura=1, ocupado=0, concluido=0, erro=0, contagem=0. State goes to OCIOSO.
- Reset asserted mid-load aborts immediately to those values. Memory is not cleared.
- All outputs are registered.
- dado_pronto rises the cycle after inicio is sampled.
- Write latency: a byte accepted at edge k appears as mem_escreve=1 with its address and data during cycle k+1 (one-cycle pulse per byte). mem_escreve=0 whenever no write is pending.
- Back-to-back bytes are accepted at 1 byte/cycle. Writes for consecutive bytes occur on consecutive cycles.
- PREENCHE issues its first write the cycle after the checksum is accepted, then 1 write/cycle for PROFUNDIDADE-N cycles.
- concluido and cpu_segura=0 take effect the cycle after the last write (last HALT write, or last data write when N==PROFUNDIDADE).
- erro goes to 1 the cycle after the offending byte is accepted.
- The checksum compare uses the sum including the Nth byte accepted in the immediately preceding cycle; no stall is allowed.

## Test plan
- Reset mid-DADOS (after 2 of 5 bytes) -> all outputs at reset values next cycle; a subsequent inicio and full frame loads correctly.
- Frame N=3, data 0x98, 0xE8, 0x99, checksum 0x19 with valid held high -> writes at addr 0,1,2 on 3 consecutive cycles. Then HALT 0xC3 is written at addresses 3..60 (58 cycles). concluido=1, cpu_segura=0, contagem=3.
- Same frame with checksum 0x20 -> erro=1, cpu_segura=1, no HALT writes. inicio then reloads successfully.
- N=0 and N=62 -> erro=1 after the length byte; mem_escreve never asserted.
- N=61 with all bytes 0x01, checksum 0x3D -> 61 writes, no PREENCHE, concluido=1. Intermittent dado_valido gaps produce no extra or dropped writes.
- Wrap check: N=2, data 0xFF, 0x02, checksum 0x01 -> pass. inicio pulsed during DADOS -> ignored, contagem continues.
